mem_req_initiator: RTL and testbench

// - Requester side of the MMU interface. Takes load/store requests from the core LSU (valid/ready), drives MMU v_adr/read_write/data_in,
//   and samples the MMU's registered valid/data_out one cycle later.
// - Returns sized, extended load data or a store completion to the core, with page-fault or misalignment status.
// - Stores narrower than a word use read-modify-write, because the MMU RAM is word-wide.

---
 rtl/mem_req_initiator.sv | 204 ++++++++++++++++++++
 tb/tb_mem_req_initiator.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mem_req_initiator.sv
// Purpose : core-side requester for the word-wide MMU; turns LSU load/store requests into MMU
//           read / write / read-modify-write cycles and returns extended load data or a store completion.
// Latency : accept edge to resp_valid is 3 cycles for loads and word stores, 5 for sub-word stores and 1 for misaligned requests.
// Backpressure: holds one request at a time. req_ready is low until the response handshakes, and resp_valid is held until resp_ready.
// Ports   : clk, reset (sync, active-low), req_* (LSU request), resp_* (LSU response),
//           mmu_v_adr/mmu_read_write/mmu_data_in (to MMU), mmu_valid/mmu_data_out (registered MMU outputs).
// Config  : define MEM_REQ_STATS_EN to add the stat_req_cnt / stat_fault_cnt output counters.
module mem_req_initiator #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int STAT_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [1:0]        resp_fault,
  output logic [ADDR_W-1:0] mmu_v_adr,
  output logic              mmu_read_write,
  output logic [DATA_W-1:0] mmu_data_in,
  input  logic              mmu_valid,
  input  logic [DATA_W-1:0] mmu_data_out
`ifdef MEM_REQ_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_req_cnt,
  output logic [STAT_W-1:0] stat_fault_cnt
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_CHECK,
    WR_ISSUE,
    WR_CHECK,
    RESP
  } state_t;

  localparam logic [1:0] FLT_OK    = 2'b00;
  localparam logic [1:0] FLT_PAGE  = 2'b01;
  localparam logic [1:0] FLT_ALIGN = 2'b10;

  state_t state, state_n;

  // Request fields captured at accept.
  logic              we_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        fault_q;
  logic [DATA_W-1:0] wr_word_q;

  logic accept;
  logic misaligned;
  logic resp_done;

  // Size code 11 behaves as a word, so size[1] alone marks a word access.
  assign misaligned = (req_size == 2'b01 && req_addr[0]) ||
                      (req_size[1] && req_addr[1:0] != 2'b00);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n        = state;
    req_ready      = 1'b0;
    resp_valid     = 1'b0;
    mmu_read_write = 1'b0;
    accept         = 1'b0;
    resp_done      = 1'b0;
    case (state)
      IDLE: begin
        // Hold off the LSU while reset is asserted even though the state is already IDLE.
        req_ready = reset;
        if (req_valid && reset) begin
          accept = 1'b1;
          if (misaligned)                state_n = RESP;
          else if (req_we && req_size[1]) state_n = WR_ISSUE;
          else                           state_n = RD_ISSUE;
        end
      end
      RD_ISSUE: state_n = RD_CHECK;
      RD_CHECK: begin
        if (!mmu_valid || !we_q) state_n = RESP;
        else                     state_n = WR_ISSUE;
      end
      WR_ISSUE: begin
        // The MMU acts on every edge, so this is the only state that may assert write.
        mmu_read_write = 1'b1;
        state_n        = WR_CHECK;
      end
      WR_CHECK: state_n = RESP;
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          resp_done = 1'b1;
          state_n   = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- lane extract / merge
  logic [DATA_W-1:0] byte_sh, half_sh, load_ext;
  logic [DATA_W-1:0] lane_mask, lane_data, merged;

  assign byte_sh = mmu_data_out >> {addr_q[1:0], 3'b000};
  assign half_sh = mmu_data_out >> {addr_q[1], 4'b0000};

  always_comb begin
    load_ext  = mmu_data_out;
    lane_mask = 32'hFFFF_FFFF;
    lane_data = wdata_q;
    case (size_q)
      2'b00: begin
        load_ext  = uns_q ? {24'h0, byte_sh[7:0]} : {{24{byte_sh[7]}}, byte_sh[7:0]};
        lane_mask = 32'h0000_00FF << {addr_q[1:0], 3'b000};
        lane_data = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        load_ext  = uns_q ? {16'h0, half_sh[15:0]} : {{16{half_sh[15]}}, half_sh[15:0]};
        lane_mask = 32'h0000_FFFF << {addr_q[1], 4'b0000};
        lane_data = {2{wdata_q[15:0]}};
      end
      default: begin
        load_ext  = mmu_data_out;
        lane_mask = 32'hFFFF_FFFF;
        lane_data = wdata_q;
      end
    endcase
  end

  assign merged = (mmu_data_out & ~lane_mask) | (lane_data & lane_mask);

  // ---------------------------------------------------------------- datapath registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      we_q      <= 1'b0;
      size_q    <= 2'b00;
      uns_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      fault_q   <= FLT_OK;
      wr_word_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            we_q    <= req_we;
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            wdata_q <= req_wdata;
            rdata_q <= '0;
            fault_q <= misaligned ? FLT_ALIGN : FLT_OK;
            // A misaligned request never touches the MMU, so the bus address is left alone.
            if (!misaligned) addr_q <= req_addr;
            if (req_we && req_size[1] && !misaligned) wr_word_q <= req_wdata;
          end
        end
        RD_CHECK: begin
          if (!mmu_valid)  fault_q   <= FLT_PAGE;
          else if (!we_q)  rdata_q   <= load_ext;
          else             wr_word_q <= merged;
        end
        WR_CHECK: fault_q <= mmu_valid ? FLT_OK : FLT_PAGE;
        default: ;
      endcase
    end
  end

  assign mmu_v_adr   = {addr_q[ADDR_W-1:2], 2'b00};
  assign mmu_data_in = wr_word_q;
  assign resp_rdata  = rdata_q;
  assign resp_fault  = fault_q;

`ifdef MEM_REQ_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      stat_req_cnt   <= '0;
      stat_fault_cnt <= '0;
    end else begin
      if (accept) stat_req_cnt <= stat_req_cnt + 1'b1;
      if (resp_done && fault_q != FLT_OK) stat_fault_cnt <= stat_fault_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_req_initiator.sv
module tb_mem_req_initiator;
  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_fault;
  logic [31:0] mmu_v_adr, mmu_data_in, mmu_data_out;
  logic        mmu_read_write, mmu_valid;
`ifdef MEM_REQ_STATS_EN
  logic [31:0] stat_req_cnt, stat_fault_cnt;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_req_initiator #(.ADDR_W(32), .DATA_W(32), .STAT_W(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .mmu_v_adr(mmu_v_adr), .mmu_read_write(mmu_read_write), .mmu_data_in(mmu_data_in),
    .mmu_valid(mmu_valid), .mmu_data_out(mmu_data_out)
`ifdef MEM_REQ_STATS_EN
    , .stat_req_cnt(stat_req_cnt), .stat_fault_cnt(stat_fault_cnt)
`endif
  );

  // MMU model: page 0x00001xxx is mapped, 16 words; outputs registered; acts every edge.
  logic [31:0] mem [0:15];
  logic        pl_en = 1'b0;
  logic [3:0]  pl_idx = 4'd0;
  logic [31:0] pl_dat = 32'd0;
  int          wr_cnt = 0;
  logic [31:0] last_wr = 32'd0;

  always @(posedge clk) begin
    mmu_valid    <= (mmu_v_adr[31:12] == 20'h00001);
    mmu_data_out <= mem[mmu_v_adr[5:2]];
    if (mmu_read_write && mmu_v_adr[31:12] == 20'h00001) mem[mmu_v_adr[5:2]] <= mmu_data_in;
    if (pl_en) mem[pl_idx] <= pl_dat;
  end

  always @(posedge clk) begin
    if (mmu_read_write) begin
      wr_cnt  = wr_cnt + 1;
      last_wr = mmu_data_in;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [3:0] idx, input logic [31:0] dat);
    pl_en = 1'b1; pl_idx = idx; pl_dat = dat;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  // Issue one request, measure accept-to-resp_valid latency, hold resp_ready low for 'hold' cycles.
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata, input int hold,
                        output int lat, output logic [31:0] rdata, output logic [1:0] fault);
    int w;
    w = 0;
    while (!req_ready && w < 16) begin @(posedge clk); #1; w++; end
    chk("req_ready_before", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 16) begin @(posedge clk); #1; lat++; end
    rdata = resp_rdata;
    fault = resp_fault;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("held_valid", {31'd0, resp_valid}, 32'd1);
      chk("held_fault", {30'd0, resp_fault}, {30'd0, fault});
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk("ready_after_resp", {31'd0, req_ready}, 32'd1);
  endtask

  int          lat, w0;
  logic [31:0] rd;
  logic [1:0]  flt;

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0; resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_fault", {30'd0, resp_fault}, 32'd0);
    chk("rst_mmu_rw", {31'd0, mmu_read_write}, 32'd0);
    chk("rst_mmu_v_adr", mmu_v_adr, 32'd0);
    chk("rst_mmu_data_in", mmu_data_in, 32'd0);
    preload(4'd1, 32'hDEADBEEF);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("idle_req_ready", {31'd0, req_ready}, 32'd1);

    // Word load, mapped.
    do_req(1'b0, 2'b10, 1'b0, 32'h0000_1004, 32'd0, 0, lat, rd, flt);
    chk("wload_lat", lat, 32'd3);
    chk("wload_rdata", rd, 32'hDEADBEEF);
    chk("wload_fault", {30'd0, flt}, 32'd0);

    // Byte loads, signed and unsigned, and a signed half load.
    preload(4'd1, 32'h8000_0000);
    do_req(1'b0, 2'b00, 1'b0, 32'h0000_1007, 32'd0, 0, lat, rd, flt);
    chk("sbyte_rdata", rd, 32'hFFFF_FF80);
    chk("sbyte_lat", lat, 32'd3);
    do_req(1'b0, 2'b00, 1'b1, 32'h0000_1007, 32'd0, 0, lat, rd, flt);
    chk("ubyte_rdata", rd, 32'h0000_0080);
    do_req(1'b0, 2'b01, 1'b0, 32'h0000_1006, 32'd0, 0, lat, rd, flt);
    chk("shalf_rdata", rd, 32'hFFFF_8000);

    // Half store read-modify-write.
    preload(4'd0, 32'h1111_2222);
    w0 = wr_cnt;
    do_req(1'b1, 2'b01, 1'b0, 32'h0000_1002, 32'h0000_ABCD, 0, lat, rd, flt);
    chk("hstore_lat", lat, 32'd5);
    chk("hstore_writes", wr_cnt - w0, 32'd1);
    chk("hstore_data_in", last_wr, 32'hABCD_2222);
    chk("hstore_fault", {30'd0, flt}, 32'd0);
    chk("hstore_rdata", rd, 32'd0);
    chk("hstore_mem", mem[0], 32'hABCD_2222);

    // Misaligned word load.
    w0 = wr_cnt;
    do_req(1'b0, 2'b10, 1'b0, 32'h0000_1002, 32'd0, 0, lat, rd, flt);
    chk("misal_lat", lat, 32'd1);
    chk("misal_fault", {30'd0, flt}, 32'd2);
    chk("misal_writes", wr_cnt - w0, 32'd0);
    chk("misal_v_adr", mmu_v_adr, 32'h0000_1000);

    // Byte store to an unmapped page, response held 4 cycles.
    w0 = wr_cnt;
    do_req(1'b1, 2'b00, 1'b0, 32'h0000_5001, 32'h0000_0077, 4, lat, rd, flt);
    chk("pf_fault", {30'd0, flt}, 32'd1);
    chk("pf_lat", lat, 32'd3);
    chk("pf_writes", wr_cnt - w0, 32'd0);
    chk("pf_rdata", rd, 32'd0);

    // Word store.
    w0 = wr_cnt;
    do_req(1'b1, 2'b10, 1'b0, 32'h0000_1008, 32'h1234_5678, 0, lat, rd, flt);
    chk("wstore_lat", lat, 32'd3);
    chk("wstore_writes", wr_cnt - w0, 32'd1);
    chk("wstore_mem", mem[2], 32'h1234_5678);

    // Reset while in RD_CHECK of a byte store.
    preload(4'd3, 32'h0102_0304);
    w0 = wr_cnt;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h0000_100C; req_wdata = 32'h0000_0055;
    @(posedge clk); #1;            // accept -> RD_ISSUE
    req_valid = 1'b0;
    @(posedge clk); #1;            // -> RD_CHECK
    reset = 1'b0;
    @(posedge clk); #1;            // forced to IDLE
    chk("rrst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rrst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rrst_v_adr", mmu_v_adr, 32'd0);
`ifdef MEM_REQ_STATS_EN
    chk("rrst_stat_req", stat_req_cnt, 32'd0);
    chk("rrst_stat_fault", stat_fault_cnt, 32'd0);
`endif
    reset = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    chk("rrst_writes", wr_cnt - w0, 32'd0);
    chk("rrst_mem", mem[3], 32'h0102_0304);
    chk("rrst_idle_ready", {31'd0, req_ready}, 32'd1);
    chk("rrst_idle_valid", {31'd0, resp_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
